// File: rtl/tiny_synth_noise_pkg.sv
// Shared constants and types for the noise voice: accumulator geometry,
// frequency word type and the LFSR reseed value.
package tiny_synth_noise_pkg;

   localparam int DEF_ACC_BITS  = 24;
   localparam int DEF_FREQ_BITS = 16;
   localparam int DEF_TAP_BIT   = 19;

   typedef logic [DEF_FREQ_BITS-1:0] freq_word_t;

   // Value the noise LFSR loads while noise_rst is high.
   localparam logic [22:0] NOISE_SEED = 23'h7FFFF8;

endpackage

// File: rtl/noise_freq_shadow.sv
// Double-buffered frequency word: writes land in a pending register and are
// promoted to the active word on the next sample strobe.
module noise_freq_shadow
   import tiny_synth_noise_pkg::*;
#(
   parameter int FREQ_BITS = DEF_FREQ_BITS
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_freq_wr,
   input  logic [FREQ_BITS-1:0] i_freq_data,
   input  logic                 i_apply,
   output logic [FREQ_BITS-1:0] o_freq_active,
   output logic                 o_freq_busy
);

   logic [FREQ_BITS-1:0] r_freq_pend;
   logic [FREQ_BITS-1:0] r_freq_active;
   logic                 r_freq_busy;
   logic                 w_promote;

   assign w_promote = i_apply & r_freq_busy;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_freq_pend   <= '0;
         r_freq_active <= '0;
         r_freq_busy   <= 1'b0;
      end else begin
         if (w_promote)
            r_freq_active <= r_freq_pend;
         // A write in the promote cycle re-arms busy with the newer word.
         if (i_freq_wr) begin
            r_freq_pend <= i_freq_data;
            r_freq_busy <= 1'b1;
         end else if (w_promote) begin
            r_freq_busy <= 1'b0;
         end
      end
   end

   assign o_freq_active = r_freq_active;
   assign o_freq_busy   = r_freq_busy;

endmodule

// File: rtl/tone_noise_clock_gen.sv
// Phase accumulator pitch source for the noise voice: drives the noise LFSR
// shift clock and reseed line. Hard sync input exists only with TINY_SYNTH_NOISE_SYNC_EN.
module tone_noise_clock_gen
   import tiny_synth_noise_pkg::*;
#(
   parameter int ACC_BITS  = DEF_ACC_BITS,
   parameter int FREQ_BITS = DEF_FREQ_BITS,
   parameter int TAP_BIT   = DEF_TAP_BIT
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_sample_en,
   input  logic                 i_freq_wr,
   input  logic [FREQ_BITS-1:0] i_freq_data,
   output logic                 o_freq_busy,
   input  logic                 i_test,
`ifdef TINY_SYNTH_NOISE_SYNC_EN
   input  logic                 i_sync_in,
`endif
   output logic                 o_noise_clk,
   output logic                 o_noise_tick,
   output logic                 o_noise_rst,
   output logic                 o_sync_out
);

   logic [ACC_BITS-1:0]  r_acc;
   logic                 r_noise_tick;
   logic                 r_sync_out;
   logic                 r_noise_rst;
   logic [FREQ_BITS-1:0] w_freq_active;
   logic [ACC_BITS-1:0]  w_acc_sum;
   logic [ACC_BITS-1:0]  w_acc_next;
   logic                 w_sync_hit;

   noise_freq_shadow #(
      .FREQ_BITS (FREQ_BITS)
   ) u_freq_shadow (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_freq_wr     (i_freq_wr),
      .i_freq_data   (i_freq_data),
      .i_apply       (i_sample_en),
      .o_freq_active (w_freq_active),
      .o_freq_busy   (o_freq_busy)
   );

   assign w_acc_sum = r_acc + ACC_BITS'(w_freq_active);

`ifdef TINY_SYNTH_NOISE_SYNC_EN
   assign w_sync_hit = i_sync_in & i_sample_en;
`else
   assign w_sync_hit = 1'b0;
`endif

   always_comb begin
      w_acc_next = r_acc;
      if (i_test || w_sync_hit)
         w_acc_next = '0;
      else if (i_sample_en)
         w_acc_next = w_acc_sum;
   end

   // Rising edges can only come from an add, so clears never raise tick/sync.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_acc        <= '0;
         r_noise_tick <= 1'b0;
         r_sync_out   <= 1'b0;
         r_noise_rst  <= 1'b1;
      end else begin
         r_acc        <= w_acc_next;
         r_noise_tick <= ~r_acc[TAP_BIT] & w_acc_next[TAP_BIT];
         r_sync_out   <= ~r_acc[ACC_BITS-1] & w_acc_next[ACC_BITS-1];
         r_noise_rst  <= i_test;
      end
   end

   assign o_noise_clk  = r_acc[TAP_BIT];
   assign o_noise_tick = r_noise_tick;
   assign o_sync_out   = r_sync_out;
   assign o_noise_rst  = r_noise_rst;

endmodule
